// File: rtl/serial_xor_cipher.sv
// serial_xor_cipher
//   Bit-serial XOR stream cipher. A KEY_SIZE-bit key and a MSG_SIZE-bit
//   message are shifted in MSB first on ser_in (key_load / msg_load strobes).
//   The message is ciphered one KEY_SIZE-bit chunk per cycle and then shifted
//   out MSB first on ser_out while out_valid is high.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ena        clock enable; all state holds when low
//   ser_in     serial data in (key and message share it)
//   key_load   key shift strobe (wins over msg_load in IDLE)
//   msg_load   message shift strobe
//   mode       00 static key, 01 rotating key, 10 passthrough, 11 inverted key
//   ser_out    serial ciphertext out, MSB first
//   out_valid  high while ser_out carries ciphertext
//   busy       high in LOAD_MSG, ENCRYPT and SHIFT_OUT
//   key_ready  a complete key is held
//   err        sticky: message load attempted in a keyed mode without a key
//   done_count completed messages, wraps
module serial_xor_cipher #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             ser_in,
  input  logic             key_load,
  input  logic             msg_load,
  input  logic [1:0]       mode,
  output logic             ser_out,
  output logic             out_valid,
  output logic             busy,
  output logic             key_ready,
  output logic             err,
  output logic [CNT_W-1:0] done_count
);

  localparam int NCHUNK = MSG_SIZE / KEY_SIZE;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ROT_W  = $clog2(KEY_SIZE);
  localparam int KCNT_W = $clog2(KEY_SIZE + 1);
  localparam int MCNT_W = $clog2(MSG_SIZE + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_KEY  = 3'd1;
  localparam logic [2:0] S_LOAD_MSG  = 3'd2;
  localparam logic [2:0] S_ENCRYPT   = 3'd3;
  localparam logic [2:0] S_SHIFT_OUT = 3'd4;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ROT_W-1:0]  ROT_LAST = ROT_W'(KEY_SIZE - 1);
  localparam logic [ROT_W-1:0]  ROT_ONE  = ROT_W'(1);
  localparam logic [KCNT_W-1:0] KEY_LAST = KCNT_W'(KEY_SIZE - 1);
  localparam logic [KCNT_W-1:0] KEY_FULL = KCNT_W'(KEY_SIZE);
  localparam logic [KCNT_W-1:0] KCNT_ONE = KCNT_W'(1);
  localparam logic [MCNT_W-1:0] MSG_LAST = MCNT_W'(MSG_SIZE - 1);
  localparam logic [MCNT_W-1:0] MSG_FULL = MCNT_W'(MSG_SIZE);
  localparam logic [MCNT_W-1:0] MCNT_ONE = MCNT_W'(1);
  localparam logic [CNT_W-1:0]  DONE_ONE = CNT_W'(1);

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [KEY_SIZE-1:0] key_r;
  logic [KCNT_W-1:0]   key_cnt_r;
  logic                key_ready_r;
  logic [MSG_SIZE-1:0] msg_r;
  logic [MCNT_W-1:0]   msg_cnt_r;   // bits loaded, then reused for bits shifted out
  logic [1:0]          mode_r;
  logic [IDX_W-1:0]    idx_r;
  logic [ROT_W-1:0]    rot_r;       // chunk index mod KEY_SIZE
  logic                ser_out_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                err_r;
  logic [CNT_W-1:0]    done_r;

  logic [KEY_SIZE-1:0] mask_s;
  logic [KEY_SIZE-1:0] chunk_cur_s;
  logic [KEY_SIZE-1:0] chunk_new_s;
  logic [MSG_SIZE-1:0] msg_enc_s;

  // Rotate key left by r positions (r < KEY_SIZE).
  function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] k,
                                               input logic [ROT_W-1:0] r);
    logic [2*KEY_SIZE-1:0] d;
    d = {k, k} << r;
    return d[2*KEY_SIZE-1:KEY_SIZE];
  endfunction

  // Key mask applied to the current chunk, chosen by the latched mode.
  always_comb begin
    mask_s = key_r;
    case (mode_r)
      2'b00:   mask_s = key_r;
      2'b01:   mask_s = rotl(key_r, rot_r);
      2'b10:   mask_s = {KEY_SIZE{1'b0}};
      2'b11:   mask_s = ~key_r;
      default: mask_s = key_r;
    endcase
  end

  // Select the chunk addressed by idx_r, cipher it and merge it back.
  always_comb begin
    chunk_cur_s = {KEY_SIZE{1'b0}};
    msg_enc_s   = msg_r;
    for (int i = 0; i < NCHUNK; i++) begin
      chunk_cur_s = chunk_cur_s |
                    ((IDX_W'(i) == idx_r) ? msg_r[i*KEY_SIZE +: KEY_SIZE] : {KEY_SIZE{1'b0}});
    end
    chunk_new_s = chunk_cur_s ^ mask_s;
    for (int i = 0; i < NCHUNK; i++) begin
      msg_enc_s[i*KEY_SIZE +: KEY_SIZE] = (IDX_W'(i) == idx_r) ? chunk_new_s
                                                              : msg_r[i*KEY_SIZE +: KEY_SIZE];
    end
  end

  // Next-state decode for the load / encrypt / shift-out sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (key_load) begin
          state_nxt_s = S_LOAD_KEY;
        end else if (msg_load && (key_ready_r || (mode == 2'b10))) begin
          state_nxt_s = S_LOAD_MSG;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD_KEY: begin
        if (key_load) begin
          state_nxt_s = S_LOAD_KEY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD_MSG: begin
        if (msg_load && (msg_cnt_r == MSG_LAST)) begin
          state_nxt_s = S_ENCRYPT;
        end else begin
          state_nxt_s = S_LOAD_MSG;
        end
      end
      S_ENCRYPT: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = S_SHIFT_OUT;
        end else begin
          state_nxt_s = S_ENCRYPT;
        end
      end
      S_SHIFT_OUT: begin
        if (msg_cnt_r == MSG_FULL) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_SHIFT_OUT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      key_r       <= {KEY_SIZE{1'b0}};
      key_cnt_r   <= {KCNT_W{1'b0}};
      key_ready_r <= 1'b0;
      msg_r       <= {MSG_SIZE{1'b0}};
      msg_cnt_r   <= {MCNT_W{1'b0}};
      mode_r      <= 2'b00;
      idx_r       <= {IDX_W{1'b0}};
      rot_r       <= {ROT_W{1'b0}};
      ser_out_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      done_r      <= {CNT_W{1'b0}};
    end else if (ena) begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_LOAD_MSG) || (state_nxt_s == S_ENCRYPT) ||
                 (state_nxt_s == S_SHIFT_OUT);
      case (state_r)
        S_IDLE: begin
          if (key_load) begin
            key_r       <= {key_r[KEY_SIZE-2:0], ser_in};
            key_cnt_r   <= KCNT_ONE;
            key_ready_r <= 1'b0;
          end else if (msg_load) begin
            if (!key_ready_r && (mode != 2'b10)) begin
              err_r <= 1'b1;
            end else begin
              msg_r     <= {msg_r[MSG_SIZE-2:0], ser_in};
              msg_cnt_r <= MCNT_ONE;
            end
          end
        end
        S_LOAD_KEY: begin
          if (key_load) begin
            key_r <= {key_r[KEY_SIZE-2:0], ser_in};
            if (key_cnt_r >= KEY_LAST) begin
              key_cnt_r   <= KEY_FULL;
              key_ready_r <= 1'b1;
            end else begin
              key_cnt_r <= key_cnt_r + KCNT_ONE;
            end
          end
        end
        S_LOAD_MSG: begin
          if (msg_load) begin
            msg_r     <= {msg_r[MSG_SIZE-2:0], ser_in};
            msg_cnt_r <= msg_cnt_r + MCNT_ONE;
            if (msg_cnt_r == MSG_LAST) begin
              mode_r <= mode;
              idx_r  <= {IDX_W{1'b0}};
              rot_r  <= {ROT_W{1'b0}};
            end
          end
        end
        S_ENCRYPT: begin
          if (idx_r == IDX_LAST) begin
            // The top chunk is ciphered on this edge, so its MSB goes straight out.
            ser_out_r   <= msg_enc_s[MSG_SIZE-1];
            msg_r       <= {msg_enc_s[MSG_SIZE-2:0], 1'b0};
            out_valid_r <= 1'b1;
            msg_cnt_r   <= MCNT_ONE;
          end else begin
            msg_r <= msg_enc_s;
            idx_r <= idx_r + IDX_ONE;
            rot_r <= (rot_r == ROT_LAST) ? {ROT_W{1'b0}} : (rot_r + ROT_ONE);
          end
        end
        S_SHIFT_OUT: begin
          if (msg_cnt_r == MSG_FULL) begin
            ser_out_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= done_r + DONE_ONE;
          end else begin
            ser_out_r <= msg_r[MSG_SIZE-1];
            msg_r     <= {msg_r[MSG_SIZE-2:0], 1'b0};
            msg_cnt_r <= msg_cnt_r + MCNT_ONE;
          end
        end
        default: begin
          ser_out_r   <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out    = ser_out_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign key_ready  = key_ready_r;
  assign err        = err_r;
  assign done_count = done_r;

endmodule

// File: tb/tb_serial_xor_cipher.sv
module tb_serial_xor_cipher;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       ser_in;
  logic       key_load;
  logic       msg_load;
  logic [1:0] mode;
  logic       ser_out;
  logic       out_valid;
  logic       busy;
  logic       key_ready;
  logic       err;
  logic [7:0] done_count;

  serial_xor_cipher dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .ser_in     (ser_in),
    .key_load   (key_load),
    .msg_load   (msg_load),
    .mode       (mode),
    .ser_out    (ser_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .key_ready  (key_ready),
    .err        (err),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_edges = 0;
  int   last_edge = 0;
  logic ena_q = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: split into bytes, XOR each with the mode's key mask.
  function automatic logic [63:0] model(input logic [63:0] m, input logic [7:0] k,
                                        input logic [1:0] md);
    logic [63:0] res;
    int ki, b, r, rot, msk;
    res = 64'd0;
    ki  = int'(k);
    for (int c = 0; c < 8; c++) begin
      b   = int'((m >> (8 * c)) & 64'hFF);
      r   = c % 8;
      rot = ((ki << r) | (ki >> (8 - r))) & 255;
      case (md)
        2'b00:   msk = ki;
        2'b01:   msk = rot;
        2'b10:   msk = 0;
        default: msk = (~ki) & 255;
      endcase
      res = res | (64'(b ^ msk) << (8 * c));
    end
    return res;
  endfunction

  // Edge bookkeeping: which rising edges actually advanced the DUT.
  initial begin
    forever begin
      @(posedge clk);
      ena_q = ena && !rst;
      if (ena && !rst) en_edges++;
    end
  end

  // Monitor: assemble output stream and compare against the scoreboard.
  initial begin
    logic [63:0] mon_word;
    int          mon_bits;
    int          mon_cyc;
    int          exp_done;
    logic        prev_v;
    exp_t        e;
    mon_word = 64'd0; mon_bits = 0; mon_cyc = 0; exp_done = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_word = 64'd0; mon_bits = 0; mon_cyc = 0; exp_done = 0; prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) begin
            chk("out_expected", 64'(sb.size() != 0), 64'd1);
            chk("latency", 64'(en_edges - last_edge), 64'd8);
          end
          mon_cyc++;
          if (ena_q) begin
            mon_word = {mon_word[62:0], ser_out};
            mon_bits++;
          end
        end else if (prev_v) begin
          exp_done++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got stream %h expected none", mon_word);
          end else begin
            e = sb.pop_front();
            chk("stream", mon_word, e.w);
            chk("valid_cycles", 64'(mon_cyc), 64'(e.cyc));
          end
          chk("bit_count", 64'(mon_bits), 64'd64);
          chk("done_count", 64'(done_count), 64'(exp_done % 256));
          chk("ser_out_idle", 64'(ser_out), 64'd0);
          mon_word = 64'd0; mon_bits = 0; mon_cyc = 0;
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic send_key(input logic [15:0] k, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      @(negedge clk);
      key_load = 1'b1;
      ser_in   = k[i];
    end
    @(negedge clk);
    key_load = 1'b0;
    ser_in   = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] m, input logic [1:0] md,
                          input logic [63:0] expw, input int cyc, input int pause_bit);
    exp_t e;
    e.w = expw;
    e.cyc = cyc;
    sb.push_back(e);
    for (int i = 63; i >= 0; i--) begin
      @(negedge clk);
      mode     = md;
      msg_load = 1'b1;
      ser_in   = m[i];
      if (i == pause_bit) begin
        ena = 1'b0;
        repeat (10) @(negedge clk);
        ena = 1'b1;
      end
    end
    @(posedge clk);
    #1 last_edge = en_edges;
    @(negedge clk);
    msg_load = 1'b0;
    ser_in   = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 1000), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rk;
    logic [1:0]  rm;
    logic [63:0] rmsg;
    rst = 1'b1; ena = 1'b1; ser_in = 1'b0; key_load = 1'b0; msg_load = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ser_out", 64'(ser_out), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_key_ready", 64'(key_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done", 64'(done_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Message without key in a keyed mode
    mode = 2'b00; msg_load = 1'b1; ser_in = 1'b1;
    @(negedge clk);
    msg_load = 1'b0; ser_in = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_no_valid", 64'(out_valid), 64'd0);
    // Passthrough needs no key
    send_msg(64'h0123456789ABCDEF, 2'b10, 64'h0123456789ABCDEF, 64, -1);
    wait_idle();
    chk("err_sticky", 64'(err), 64'd1);

    // Directed key A5, all modes
    send_key(16'h00A5, 8);
    chk("key_ready_8", 64'(key_ready), 64'd1);
    send_msg(64'hA3B1F9D2E7C6A594, 2'b00, 64'h06145C7742630031, 64, -1);
    wait_idle();
    send_msg(64'hA3B1F9D2E7C6A594, 2'b01, 64'h71D84D88CA50EE31, 64, -1);
    wait_idle();
    send_msg(64'hA3B1F9D2E7C6A594, 2'b11, 64'hF9EBA388BD9CFFCE, 64, -1);
    wait_idle();
    send_msg(64'hA3B1F9D2E7C6A594, 2'b10, 64'hA3B1F9D2E7C6A594, 64, -1);
    wait_idle();

    // Over-long key: last 8 bits win
    send_key(16'h07A5, 11);
    chk("key_ready_11", 64'(key_ready), 64'd1);
    send_msg(64'hA3B1F9D2E7C6A594, 2'b00, 64'h06145C7742630031, 64, -1);
    wait_idle();

    // Short key leaves key_ready low
    send_key(16'h0015, 5);
    chk("key_ready_5", 64'(key_ready), 64'd0);

    // ena stalls in LOAD_MSG and SHIFT_OUT
    send_key(16'h00A5, 8);
    send_msg(64'hA3B1F9D2E7C6A594, 2'b00, 64'h06145C7742630031, 74, 30);
    wait_valid();
    repeat (20) @(negedge clk);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    wait_idle();

    // Randomised keys, modes and messages
    for (int t = 0; t < 6; t++) begin
      rk   = 8'($urandom_range(0, 255));
      rm   = 2'($urandom_range(0, 3));
      rmsg = {32'($urandom), 32'($urandom)};
      send_key({8'd0, rk}, 8);
      send_msg(rmsg, rm, model(rmsg, rk, rm), 64, -1);
      wait_idle();
    end

    // Reset during SHIFT_OUT
    send_key(16'h00A5, 8);
    send_msg(64'hA3B1F9D2E7C6A594, 2'b00, 64'h06145C7742630031, 64, -1);
    wait_valid();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("arst_ser_out", 64'(ser_out), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_key_ready", 64'(key_ready), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_done", 64'(done_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_done", 64'(done_count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_xor_cipher.md
Name: serial_xor_cipher

Overview:
Parametrised serial XOR stream-cipher core. It is the next generation of the tile's fixed 8-bit-key / 64-bit-message XOR engine. A key and a message are shifted in bit-serially, MSB first, on one data line under separate load strobes. The message is ciphered chunk-by-chunk in one of four key modes and shifted back out serially with a valid flag. It sits behind the tile's top-level pin mapping: ui_in carries data and strobes, uo_out carries data and status.

Parameters:
MSG_SIZE, 64, message length in bits; must be an integer multiple of KEY_SIZE.
KEY_SIZE, 8, key and chunk length in bits; must be >= 2.
CNT_W, 8, width of the completed-message counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ena  input  1  clock enable; when 0, all state holds.
ser_in  input  1  serial data in, MSB first, shared by key and message.
key_load  input  1  key shift strobe.
msg_load  input  1  message shift strobe.
mode  input  2  00 static key, 01 rotating key, 10 passthrough, 11 inverted key; sampled on the edge entering ENCRYPT.
ser_out  output  1  serial ciphertext, MSB first.
out_valid  output  1  high while ser_out carries ciphertext.
busy  output  1  high in LOAD_MSG, ENCRYPT and SHIFT_OUT.
key_ready  output  1  a full KEY_SIZE-bit key is held.
err  output  1  sticky: a message load was attempted without a ready key in a keyed mode.
done_count  output  CNT_W  number of completed messages; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any state): state=IDLE. Key, message and counters clear. ser_out, out_valid, busy, key_ready and err are 0. done_count=0. All outputs are registered.
- ena=0: no state, counter or register changes; outputs hold their values.
- States: IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SHIFT_OUT.
- IDLE, key_load=1: enter LOAD_KEY. The bit counter clears, key_ready clears, and ser_in is shifted into the key LSB on this same edge. key_load has priority over msg_load.
- LOAD_KEY: each edge with key_load=1 shifts ser_in in. key_ready=1 once KEY_SIZE bits have been received; the counter saturates there. Extra bits keep shifting, so the last KEY_SIZE bits win. key_load=0 returns to IDLE. A partial key leaves key_ready=0.
- IDLE, msg_load=1, key_load=0:
  - If key_ready=0 and mode!=10: set err, stay in IDLE, ignore the bit.
  - Otherwise enter LOAD_MSG, capturing the first bit.
- LOAD_MSG: each edge with msg_load=1 shifts one bit. The edge capturing bit MSG_SIZE enters ENCRYPT regardless of msg_load. msg_load=0 before the message is full holds the partial message and waits. key_load is ignored.
- ENCRYPT: one chunk per cycle, NCHUNK=MSG_SIZE/KEY_SIZE cycles. Chunk 0 is the least-significant KEY_SIZE bits. Chunk i becomes:
  - mode 00: chunk ^ key.
  - mode 01: chunk ^ rotl(key, i mod KEY_SIZE).
  - mode 10: chunk unchanged.
  - mode 11: chunk ^ ~key.
- Enter SHIFT_OUT on the edge that processes the last chunk. On that edge out_valid=1 and ser_out=bit MSG_SIZE-1.
- Latency: out_valid rises on the NCHUNK-th rising edge after the edge that captured the final message bit (8 edges with defaults).
- SHIFT_OUT: each edge presents the next lower bit. out_valid stays high for exactly MSG_SIZE cycles. On the next edge: IDLE, out_valid=0, ser_out=0, done_count+1.
- key_load and msg_load are ignored during ENCRYPT and SHIFT_OUT. The key is retained across messages.
- err clears only on rst. err does not block later valid loads.
- Reset mid-operation aborts immediately. No partial output follows.

Test Plan:
- Load key A5, mode 00, message A3B1F9D2E7C6A594 -> 64-bit ser_out stream = 06145C7742630031; out_valid high 64 cycles, rising 8 edges after the last message bit; done_count=1.
- Same key and message, mode 01 -> 71D84D88CA50EE31. Mode 11 -> F9EBA388BD9CFFCE. Mode 10 -> A3B1F9D2E7C6A594.
- After reset, msg_load with no key in mode 00 -> err=1, busy=0, no out_valid. Then mode 10, message 0123456789ABCDEF -> identical stream out, err stays 1.
- Key load of 11 bits ending ...A5 -> key_ready=1, mode 00 result as in the first test. A 5-bit key load -> key_ready=0.
- ena=0 for 10 cycles mid-LOAD_MSG and mid-SHIFT_OUT -> stream unchanged versus an uninterrupted run, and out_valid is extended by the 10 cycles.
- rst pulse during SHIFT_OUT -> all outputs 0 asynchronously, key_ready=0, done_count=0.
